multdiv_sequencer: RTL

Multi-cycle sequencer that lets the single-cycle processor share the iterative multiply/divide unit. It watches the decoded instruction and detects R-type `mul`/`div`. It then pulses the unit's start control, stalls the pipeline front end until the result is ready, and issues one register-file write of the product/quotient, or of the `rstatus` code on exception. It sits between the instruction decode/control logic and the regfile write port mux.

---
 rtl/multdiv_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/multdiv_sequencer.sv
// Sequences a shared iterative multiply/divide unit for a single-cycle core:
// detects mul/div, pulses start, stalls fetch, and issues one regfile write.
// Optional macro MD_TIMEOUT_EN aborts an operation after TIMEOUT BUSY cycles.
module multdiv_sequencer #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          instr_valid,
  input  logic [4:0]    opcode,
  input  logic [4:0]    aluop,
  input  logic [4:0]    rd,
  input  logic [DW-1:0] data_result,
  input  logic          data_resultRDY,
  input  logic          data_exception,
  output logic          ctrl_MULT,
  output logic          ctrl_DIV,
  output logic          stall,
  output logic          md_we,
  output logic [4:0]    md_waddr,
  output logic [DW-1:0] md_wdata,
  output logic          md_busy,
  output logic          md_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [4:0] RSTATUS = 5'd30;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if ((2 ** CNT_W) <= TIMEOUT) begin : g_bad_cnt_w
    $error("multdiv_sequencer: CNT_W too narrow for TIMEOUT");
  end

  state_t           r_state, w_state_nxt;
  logic             r_op_div, w_op_div_nxt;
  logic [4:0]       r_rd, w_rd_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ctrl_mult, w_ctrl_mult_nxt;
  logic             r_ctrl_div, w_ctrl_div_nxt;
  logic             r_md_we, w_md_we_nxt;
  logic [4:0]       r_md_waddr, w_md_waddr_nxt;
  logic [DW-1:0]    r_md_wdata, w_md_wdata_nxt;
  logic             r_md_busy;
  logic             r_md_timeout, w_md_timeout_nxt;
  logic             w_md_req, w_done, w_exc;

  assign w_md_req = instr_valid && (opcode == 5'b00000) &&
                    ((aluop == 5'b00110) || (aluop == 5'b00111));

  // Handshake: start is a one-cycle pulse in the first BUSY cycle; the unit's
  // RDY is a level qualified only while BUSY and only after that pulse cycle
  // (counter != 0), so stale RDY from a previous op can never complete a new one.
  always_comb begin
    w_state_nxt      = r_state;
    w_op_div_nxt     = r_op_div;
    w_rd_nxt         = r_rd;
    w_cnt_nxt        = r_cnt;
    w_ctrl_mult_nxt  = 1'b0;
    w_ctrl_div_nxt   = 1'b0;
    w_md_we_nxt      = 1'b0;
    w_md_waddr_nxt   = r_md_waddr;
    w_md_wdata_nxt   = r_md_wdata;
    w_md_timeout_nxt = r_md_timeout;
    w_done           = 1'b0;
    w_exc            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_md_req) begin
          w_state_nxt     = S_BUSY;
          w_op_div_nxt    = aluop[0];
          w_rd_nxt        = rd;
          w_cnt_nxt       = '0;
          w_ctrl_mult_nxt = ~aluop[0];
          w_ctrl_div_nxt  = aluop[0];
        end
      end
      S_BUSY: begin
        if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
        if ((r_cnt != '0) && data_resultRDY) begin
          w_done = 1'b1;
          w_exc  = data_exception;
        end
`ifdef MD_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT)) begin
          w_done           = 1'b1;
          w_exc            = 1'b1;
          w_md_timeout_nxt = 1'b1;
        end
`endif
        if (w_done) begin
          w_state_nxt = S_WB;
          if (w_exc) begin
            w_md_we_nxt    = 1'b1;
            w_md_waddr_nxt = RSTATUS;
            w_md_wdata_nxt = r_op_div ? DW'(5) : DW'(4);
          end else begin
            w_md_we_nxt    = (r_rd != 5'd0);
            w_md_waddr_nxt = r_rd;
            w_md_wdata_nxt = data_result;
          end
        end
      end
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_op_div     <= 1'b0;
      r_rd         <= 5'd0;
      r_cnt        <= '0;
      r_ctrl_mult  <= 1'b0;
      r_ctrl_div   <= 1'b0;
      r_md_we      <= 1'b0;
      r_md_waddr   <= 5'd0;
      r_md_wdata   <= '0;
      r_md_busy    <= 1'b0;
      r_md_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_op_div     <= w_op_div_nxt;
      r_rd         <= w_rd_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ctrl_mult  <= w_ctrl_mult_nxt;
      r_ctrl_div   <= w_ctrl_div_nxt;
      r_md_we      <= w_md_we_nxt;
      r_md_waddr   <= w_md_waddr_nxt;
      r_md_wdata   <= w_md_wdata_nxt;
      r_md_busy    <= (w_state_nxt != S_IDLE);
      r_md_timeout <= w_md_timeout_nxt;
    end
  end

  // Released in WB so the PC advances on the writeback edge.
  assign stall      = ((r_state == S_IDLE) && w_md_req) || (r_state == S_BUSY);
  assign ctrl_MULT  = r_ctrl_mult;
  assign ctrl_DIV   = r_ctrl_div;
  assign md_we      = r_md_we;
  assign md_waddr   = r_md_waddr;
  assign md_wdata   = r_md_wdata;
  assign md_busy    = r_md_busy;
  assign md_timeout = r_md_timeout;

endmodule
